// File: rtl/led_breath_pwm.sv
// led_breath_pwm: breathing-LED PWM driver.
// The duty ramps 0 -> full, holds, ramps back to 0, and repeats. A rising edge
// on SYNC_I restarts the ramp. PWM_O is a registered compare of the PWM counter
// against the effective duty.
// Build option: define LED_BREATH_GAMMA_EN to square the duty into a
// perceptual curve before the compare. DUTY_O always reports the linear duty.
module led_breath_pwm #(
  parameter int PWM_BITS         = 8,
  parameter int PRESCALE         = 4,
  parameter int STEP_PWM_PERIODS = 2,
  parameter int HOLD_STEPS       = 16
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                EN_I,
  input  logic                SYNC_I,
  output logic                PWM_O,
  output logic [PWM_BITS-1:0] DUTY_O,
  output logic                DIR_O,
  output logic                CYCLE_DONE_O
);

  localparam int PS_W = (PRESCALE > 1)         ? $clog2(PRESCALE)         : 1;
  localparam int ST_W = (STEP_PWM_PERIODS > 1) ? $clog2(STEP_PWM_PERIODS) : 1;
  localparam int HD_W = (HOLD_STEPS > 1)       ? $clog2(HOLD_STEPS)       : 1;

  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [ST_W-1:0]     ST_LAST  = ST_W'(STEP_PWM_PERIODS - 1);
  localparam logic [HD_W-1:0]     HD_LAST  = HD_W'(HOLD_STEPS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] DUTY_PRE = DUTY_MAX - 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_RISE, S_HOLD, S_FALL} state_e;

  state_e              state_q, state_d;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [ST_W-1:0]     step_q, step_d;
  logic [HD_W-1:0]     hold_q, hold_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                sync_q, sync_d;
  logic                pwm_q, pwm_d;
  logic                done_q, done_d;

  logic                tick, boundary, step, sync_edge;
  logic [PWM_BITS-1:0] duty_eff;

  assign tick      = (presc_q == PS_LAST);
  assign boundary  = tick && (pwm_cnt_q == DUTY_MAX);
  assign step      = boundary && (step_q == ST_LAST);
  assign sync_edge = SYNC_I && !sync_q;

`ifdef LED_BREATH_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  // Squared duty, keeping the upper half of the product.
  assign duty_sq  = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};
  assign duty_eff = PWM_BITS'(duty_sq >> PWM_BITS);
`else
  assign duty_eff = duty_q;
`endif

  // Next-state: enable drop, then entry from idle, then sync restart, then the step FSM.
  always_comb begin
    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    step_d    = boundary ? ((step_q == ST_LAST) ? '0 : step_q + 1'b1) : step_q;
    hold_d    = hold_q;
    duty_d    = duty_q;
    done_d    = 1'b0;
    sync_d    = SYNC_I;
    pwm_d     = (pwm_cnt_q < duty_eff);

    if (!EN_I || state_q == S_IDLE || sync_edge) begin
      // All three paths park every counter at zero; only the target state differs.
      state_d   = EN_I ? S_RISE : S_IDLE;
      presc_d   = '0;
      pwm_cnt_d = '0;
      step_d    = '0;
      hold_d    = '0;
      duty_d    = '0;
    end else if (step) begin
      unique case (state_q)
        S_RISE: begin
          duty_d = duty_q + 1'b1;
          if (duty_q == DUTY_PRE) begin
            hold_d  = '0;
            state_d = (HOLD_STEPS == 0) ? S_FALL : S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_q == HD_LAST) begin
            hold_d  = '0;
            state_d = S_FALL;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        S_FALL: begin
          duty_d = duty_q - 1'b1;
          if (duty_q == {{(PWM_BITS-1){1'b0}}, 1'b1}) begin
            done_d  = 1'b1;
            state_d = S_RISE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      step_q    <= '0;
      hold_q    <= '0;
      duty_q    <= '0;
      sync_q    <= 1'b0;
      pwm_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      step_q    <= step_d;
      hold_q    <= hold_d;
      duty_q    <= duty_d;
      sync_q    <= sync_d;
      pwm_q     <= pwm_d;
      done_q    <= done_d;
    end
  end

  assign PWM_O        = pwm_q;
  assign DUTY_O       = duty_q;
  assign DIR_O        = (state_q == S_RISE) || (state_q == S_HOLD);
  assign CYCLE_DONE_O = done_q;

endmodule
